// File: rtl/dither_ctrl.sv
// Dither sequencer: owns the six LFSR seeds, loads them into the generator and
// ramps the dither gain one step per sample so dither never switches abruptly.
module dither_ctrl #(
  parameter int DW        = 24,
  parameter int GAIN_BITS = 8,
  parameter int SEED_W    = 25
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sample_stb,
  input  logic                   dith_en,
  input  logic                   reseed_req,
  input  logic                   seed_wr,
  input  logic [2:0]             seed_idx,
  input  logic [SEED_W-1:0]      seed_wdata,
  input  logic signed [DW-1:0]   dith_i,
  output logic                   lfsr_adv,
  output logic                   lfsr_load,
  output logic [2:0]             lfsr_load_idx,
  output logic [SEED_W-1:0]      lfsr_load_data,
  output logic signed [DW-1:0]   dith_o,
  output logic [GAIN_BITS:0]     gain_o,
  output logic [2:0]             state_o,
  output logic                   busy
);

  localparam int NSEEDS = 6;
  localparam int PW     = DW + GAIN_BITS + 1;
  localparam logic [2:0]         LAST_IDX = 3'd5;
  localparam logic [GAIN_BITS:0] FULL     = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic [GAIN_BITS:0] GAIN_ONE = {{GAIN_BITS{1'b0}}, 1'b1};
  localparam logic [SEED_W-1:0]  SEED_RST [NSEEDS] = '{
    25'h0ABCDE, 25'h08FA82, 25'h13CBAF, 25'h3B113F, 25'h512345, 25'h12882B
  };

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_LOAD      = 3'd1,
    S_RAMP_UP   = 3'd2,
    S_ON        = 3'd3,
    S_RAMP_DOWN = 3'd4
  } state_e;

  state_e                    state_q;
  logic [GAIN_BITS:0]        gain_q;
  logic signed [DW-1:0]      dith_q;
  logic                      pending_q;
  logic                      load_q;
  logic [2:0]                load_idx_q;
  logic [SEED_W-1:0]         load_data_q;
  logic [SEED_W-1:0]         seed_q [NSEEDS];

  logic [GAIN_BITS:0]        gain_up_d;
  logic [GAIN_BITS:0]        gain_dn_d;
  logic [2:0]                load_idx_d;
  logic                      start_load_d;
  logic signed [PW-1:0]      dith_ext_d;
  logic signed [PW-1:0]      gain_ext_d;
  logic signed [PW-1:0]      prod_d;
  logic signed [DW-1:0]      scaled_d;
  logic                      unused_prod;

  // Saturating gain steps; FULL and 0 are sticky limits.
  assign gain_up_d  = (gain_q == FULL) ? FULL : gain_q + GAIN_ONE;
  assign gain_dn_d  = (gain_q == '0)   ? '0   : gain_q - GAIN_ONE;
  assign load_idx_d = load_idx_q + 3'd1;

  assign start_load_d = ((state_q == S_OFF) && (dith_en || reseed_req || pending_q)) ||
                        ((state_q == S_ON)  && (reseed_req || pending_q));

  // Arithmetic shift of the full product floors toward -inf; the slice is that shift.
  assign dith_ext_d  = {{(PW-DW){dith_i[DW-1]}}, dith_i};
  assign gain_ext_d  = {{(PW-GAIN_BITS-1){1'b0}}, gain_q};
  assign prod_d      = dith_ext_d * gain_ext_d;
  assign scaled_d    = prod_d[GAIN_BITS +: DW];
  assign unused_prod = ^{prod_d[PW-1], prod_d[GAIN_BITS-1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the seed file is reset as well, so the generator restarts from a known sequence.
      for (int i = 0; i < NSEEDS; i++) seed_q[i] <= SEED_RST[i];
      state_q     <= S_OFF;
      gain_q      <= '0;
      dith_q      <= '0;
      pending_q   <= 1'b0;
      load_q      <= 1'b0;
      load_idx_q  <= '0;
      load_data_q <= '0;
    end else begin
      // Load reads the old seed here, so a same-cycle write lands after the load.
      if (seed_wr && (seed_idx <= LAST_IDX)) seed_q[seed_idx] <= seed_wdata;

      if (sample_stb && (state_q != S_LOAD))
        dith_q <= (state_q == S_OFF) ? '0 : scaled_d;

      // NOTE: defaults first; later non-blocking assignments in this block override them.
      load_q      <= 1'b0;
      load_idx_q  <= '0;
      load_data_q <= '0;

      case (state_q)
        S_LOAD: begin
          if (load_idx_q == LAST_IDX) begin
            if (dith_en) state_q <= (gain_q == FULL) ? S_ON : S_RAMP_UP;
            else         state_q <= (gain_q == '0)   ? S_OFF : S_RAMP_DOWN;
          end else begin
            load_q      <= 1'b1;
            load_idx_q  <= load_idx_d;
            load_data_q <= seed_q[load_idx_d];
          end
        end
        S_RAMP_UP: begin
          if (reseed_req) pending_q <= 1'b1;
          if (!dith_en) begin
            state_q <= S_RAMP_DOWN;
          end else if (sample_stb) begin
            gain_q <= gain_up_d;
            if (gain_up_d == FULL) state_q <= S_ON;
          end
        end
        S_ON: begin
          if (!dith_en) state_q <= S_RAMP_DOWN;
        end
        S_RAMP_DOWN: begin
          if (reseed_req) pending_q <= 1'b1;
          if (dith_en) begin
            state_q <= S_RAMP_UP;
          end else if (sample_stb) begin
            gain_q <= gain_dn_d;
            if (gain_dn_d == '0) state_q <= S_OFF;
          end
        end
        default: ;
      endcase

      // Reseed outranks any dith_en change in OFF/ON; the exit rule resolves it later.
      if (start_load_d) begin
        state_q     <= S_LOAD;
        pending_q   <= 1'b0;
        load_q      <= 1'b1;
        load_idx_q  <= '0;
        load_data_q <= seed_q[0];
      end
    end
  end

  assign lfsr_adv       = sample_stb && ((state_q == S_RAMP_UP) || (state_q == S_ON) ||
                                         (state_q == S_RAMP_DOWN));
  assign lfsr_load      = load_q;
  assign lfsr_load_idx  = load_idx_q;
  assign lfsr_load_data = load_data_q;
  assign dith_o         = dith_q;
  assign gain_o         = gain_q;
  assign state_o        = state_q;
  assign busy           = (state_q == S_LOAD);

endmodule

// File: tb/tb_dither_ctrl.sv
// Scoreboard bench for dither_ctrl: strobe and load expectations are queued by the
// stimulus and consumed by independent monitors on the falling clock edge.
module tb_dither_ctrl;

  localparam int ST_OFF = 0, ST_LOAD = 1, ST_RU = 2, ST_ON = 3, ST_RD = 4;

  logic              clock, reset, sample_stb, dith_en, reseed_req, seed_wr;
  logic [2:0]        seed_idx;
  logic [24:0]       seed_wdata;
  logic signed [23:0] dith_i;
  logic              lfsr_adv, lfsr_load, busy;
  logic [2:0]        lfsr_load_idx, state_o;
  logic [24:0]       lfsr_load_data;
  logic signed [23:0] dith_o;
  logic [8:0]        gain_o;

  dither_ctrl dut (
    .clock(clock), .reset(reset), .sample_stb(sample_stb), .dith_en(dith_en),
    .reseed_req(reseed_req), .seed_wr(seed_wr), .seed_idx(seed_idx),
    .seed_wdata(seed_wdata), .dith_i(dith_i), .lfsr_adv(lfsr_adv),
    .lfsr_load(lfsr_load), .lfsr_load_idx(lfsr_load_idx),
    .lfsr_load_data(lfsr_load_data), .dith_o(dith_o), .gain_o(gain_o),
    .state_o(state_o), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct { bit adv; int dith; int gain; int st; } resp_t;
  typedef struct { int idx; int data; } ld_t;

  resp_t sb_q[$];
  ld_t   ld_q[$];
  resp_t cur;
  bit    due = 1'b0;
  int    n_checks = 0;
  int    n_fail = 0;
  logic [24:0] seed_m [6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic strobe(input int di, input int e_dith, input int e_gain,
                        input int e_state, input bit e_adv);
    resp_t r;
    r.adv = e_adv; r.dith = e_dith; r.gain = e_gain; r.st = e_state;
    sb_q.push_back(r);
    sample_stb = 1'b1;
    dith_i     = 24'(di);
    cyc();
    sample_stb = 1'b0;
  endtask

  task automatic push_load(input int n);
    ld_t l;
    for (int i = 0; i < n; i++) begin
      l.idx = i; l.data = int'(seed_m[i]);
      ld_q.push_back(l);
    end
  endtask

  // Strobe monitor: lfsr_adv in the strobe cycle, scaled output one clock later.
  always @(negedge clock) begin
    if (due) begin
      check("dith_o", int'(dith_o), cur.dith);
      check("gain_o", int'(gain_o), cur.gain);
      check("state_after_stb", int'(state_o), cur.st);
      due = 1'b0;
    end
    if (sample_stb === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("stb_unexpected", 1, 0);
      end else begin
        cur = sb_q.pop_front();
        check("lfsr_adv", int'(lfsr_adv), int'(cur.adv));
        due = 1'b1;
      end
    end
  end

  // Load monitor: every lfsr_load cycle must match the next queued seed.
  always @(negedge clock) begin
    if (lfsr_load === 1'b1) begin
      if (ld_q.size() == 0) begin
        check("load_unexpected", int'(lfsr_load_idx), -1);
      end else begin
        ld_t l;
        l = ld_q.pop_front();
        check("load_idx", int'(lfsr_load_idx), l.idx);
        check("load_data", int'(lfsr_load_data), l.data);
        check("load_busy", int'(busy), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; sample_stb = 1'b0; dith_en = 1'b0; reseed_req = 1'b0;
    seed_wr = 1'b0; seed_idx = '0; seed_wdata = '0; dith_i = '0;
    seed_m = '{25'h0ABCDE, 25'h08FA82, 25'h13CBAF, 25'h3B113F, 25'h512345, 25'h12882B};
    repeat (3) cyc();

    check("rst_state", int'(state_o), ST_OFF);
    check("rst_gain", int'(gain_o), 0);
    check("rst_dith", int'(dith_o), 0);
    check("rst_load", int'(lfsr_load), 0);
    check("rst_load_idx", int'(lfsr_load_idx), 0);
    check("rst_load_data", int'(lfsr_load_data), 0);
    check("rst_busy", int'(busy), 0);

    // Enable with no strobes: six-cycle seed load, then ramp up from gain 0.
    reset = 1'b0; dith_en = 1'b1; push_load(6);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (busy) n++;
      if (state_o == 3'(ST_RU)) break;
    end
    check("load_cycles", n, 6);
    check("t1_state", int'(state_o), ST_RU);
    check("t1_gain", int'(gain_o), 0);
    check("t1_dith", int'(dith_o), 0);

    // Full ramp up with +1000; output uses the pre-strobe gain.
    for (int k = 1; k <= 256; k++)
      strobe(1000, (1000 * (k - 1)) / 256, k, (k == 256) ? ST_ON : ST_RU, 1'b1);
    strobe(1000, 1000, 256, ST_ON, 1'b1);

    // Ramp down 10 steps, then back up; -1000 at gain 246 floors to -961.
    dith_en = 1'b0; cyc();
    check("t3_rd", int'(state_o), ST_RD);
    for (int k = 1; k <= 10; k++)
      strobe(1000, (1000 * (257 - k)) / 256, 256 - k, ST_RD, 1'b1);
    dith_en = 1'b1; cyc();
    check("t3_ru", int'(state_o), ST_RU);
    check("t3_gain", int'(gain_o), 246);
    strobe(-1000, -961, 247, ST_RU, 1'b1);
    for (int g = 247; g <= 255; g++)
      strobe(1000, (1000 * g) / 256, g + 1, (g == 255) ? ST_ON : ST_RU, 1'b1);

    // Seed write then reseed in ON; strobes during LOAD are ignored.
    seed_wr = 1'b1; seed_idx = 3'd3; seed_wdata = 25'h000001; seed_m[3] = 25'h000001;
    cyc();
    seed_wr = 1'b0;
    reseed_req = 1'b1; push_load(6); cyc(); reseed_req = 1'b0;
    check("t4_busy", int'(busy), 1);
    check("t4_gain", int'(gain_o), 256);
    strobe(0, 996, 256, ST_LOAD, 1'b0);
    strobe(0, 996, 256, ST_LOAD, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (state_o == 3'(ST_ON)) break;
      cyc();
    end
    check("t4_back_on", int'(state_o), ST_ON);
    check("t4_gain_full", int'(gain_o), 256);

    // Reseed during ramp-down waits for OFF; a reseed inside LOAD is dropped.
    dith_en = 1'b0; cyc();
    check("t5_rd", int'(state_o), ST_RD);
    reseed_req = 1'b1; cyc(); reseed_req = 1'b0;
    check("t5_no_load", int'(state_o), ST_RD);
    push_load(6);
    for (int k = 1; k <= 256; k++)
      strobe(512, 2 * (257 - k), 256 - k, (k == 256) ? ST_OFF : ST_RD, 1'b1);
    check("t5_off_once", int'(state_o), ST_OFF);
    cyc();
    check("t5_pending_load", int'(state_o), ST_LOAD);
    reseed_req = 1'b1; cyc(); reseed_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (state_o == 3'(ST_OFF)) break;
      cyc();
    end
    check("t5_off", int'(state_o), ST_OFF);
    check("t5_gain", int'(gain_o), 0);
    repeat (10) cyc();
    check("t5_reseed_dropped", int'(state_o), ST_OFF);

    // Reset in the middle of a load aborts it and restores default seeds.
    dith_en = 1'b1; push_load(3);
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (lfsr_load_idx == 3'd2) break;
    end
    check("t6_at_idx2", int'(lfsr_load_idx), 2);
    reset = 1'b1; dith_en = 1'b0; cyc();
    check("t6_state", int'(state_o), ST_OFF);
    check("t6_load", int'(lfsr_load), 0);
    check("t6_gain", int'(gain_o), 0);
    check("t6_busy", int'(busy), 0);
    reset = 1'b0; seed_m[3] = 25'h3B113F; push_load(6);
    reseed_req = 1'b1; cyc(); reseed_req = 1'b0;
    check("t6_reload", int'(state_o), ST_LOAD);
    for (int i = 0; i < 20; i++) begin
      if (state_o == 3'(ST_OFF)) break;
      cyc();
    end
    check("t6_off", int'(state_o), ST_OFF);

    repeat (3) cyc();
    check("sb_drained", sb_q.size(), 0);
    check("loads_drained", ld_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
